// File: rtl/sonic_tx_page_scheduler.sv
// Read-side page sequencer for the 66-bit Tx circular buffer (rd_clk / gearbox domain).
// Define SONIC_TX_SCHED_STATS_EN to add the idle_cnt/page_cnt statistics counters and stats_clr.
module sonic_tx_page_scheduler #(
    parameter int unsigned NUM_PAGES     = 32,
    parameter int unsigned BLKS_PER_PAGE = 496,
    parameter int unsigned BLK_OFFSET    = 16,
    parameter int unsigned RD_LATENCY    = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic        page_done,
    input  logic        blk_req,
`ifdef SONIC_TX_SCHED_STATS_EN
    input  logic        stats_clr,
    output logic [31:0] idle_cnt,
    output logic [31:0] page_cnt,
`endif
    output logic [13:0] rd_address,
    output logic        rdreq,
    output logic        blk_valid,
    output logic        blk_idle,
    output logic        page_free,
    output logic [5:0]  pages_ready,
    output logic        overflow,
    output logic [1:0]  state
);

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned PGN_W  = $clog2(NUM_PAGES);
    localparam int unsigned BLK_W  = ADDR_W - PGN_W;
    localparam int unsigned CNT_W  = PGN_W + 1;
    localparam int unsigned RDY_W  = 6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SEND  = 2'd1,
        ST_STOP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PGN_W-1:0]        pgn_q, pgn_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic [CNT_W-1:0]        rdy_q, rdy_d;
    logic                    ovf_q, ovf_d;
    logic                    free_q, free_d;
    logic [RD_LATENCY-1:0]   vpipe_q, vpipe_d;
    logic [RD_LATENCY-1:0]   ipipe_q, ipipe_d;

    logic rdreq_c;
    logic last_c;
    logic accept_c;

    // Read strobe is gated by the request only in SEND; the address is already stable from registers.
    assign rdreq_c  = blk_req & (state_q == ST_SEND);
    assign last_c   = rdreq_c & (blk_q == BLK_W'(BLKS_PER_PAGE - 1));
    assign accept_c = page_done & (rdy_q < CNT_W'(NUM_PAGES));

    always_comb begin
        state_d = state_q;
        pgn_d   = pgn_q;
        blk_d   = blk_q;
        rdy_d   = rdy_q;
        ovf_d   = ovf_q | (page_done & ~accept_c);
        free_d  = last_c;

        // Accept and completion in the same cycle cancel out.
        if (accept_c && !last_c) begin
            rdy_d = rdy_q + CNT_W'(1);
        end else if (!accept_c && last_c && (rdy_q != '0)) begin
            rdy_d = rdy_q - CNT_W'(1);
        end

        if (rdreq_c) begin
            if (last_c) begin
                blk_d = '0;
                pgn_d = pgn_q + PGN_W'(1);
            end else begin
                blk_d = blk_q + BLK_W'(1);
            end
        end

        // Each request cycle leaves exactly one of valid/idle at the far end of the pipe.
        vpipe_d[0] = rdreq_c;
        ipipe_d[0] = blk_req & ~rdreq_c;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            ipipe_d[i] = ipipe_q[i-1];
        end

        case (state_q)
            ST_EMPTY: begin
                if ((rdy_q != '0) && tx_enable) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (last_c) begin
                    if (rdy_d == '0)     state_d = ST_EMPTY;
                    else if (!tx_enable) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_enable) state_d = (rdy_q != '0) ? ST_SEND : ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            pgn_q   <= '0;
            blk_q   <= '0;
            rdy_q   <= '0;
            ovf_q   <= 1'b0;
            free_q  <= 1'b0;
            vpipe_q <= '0;
            ipipe_q <= '0;
        end else begin
            state_q <= state_d;
            pgn_q   <= pgn_d;
            blk_q   <= blk_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
            free_q  <= free_d;
            vpipe_q <= vpipe_d;
            ipipe_q <= ipipe_d;
        end
    end

    assign rd_address  = {pgn_q, blk_q + BLK_W'(BLK_OFFSET)};
    assign rdreq       = rdreq_c;
    assign blk_valid   = vpipe_q[RD_LATENCY-1];
    assign blk_idle    = ipipe_q[RD_LATENCY-1];
    assign page_free   = free_q;
    assign pages_ready = RDY_W'(rdy_q);
    assign overflow    = ovf_q;
    assign state       = state_q;

`ifdef SONIC_TX_SCHED_STATS_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] page_cnt_q, page_cnt_d;

    // Saturating event counters; synchronous clear wins over counting.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        page_cnt_d = page_cnt_q;
        if (stats_clr) begin
            idle_cnt_d = '0;
            page_cnt_d = '0;
        end else begin
            if (blk_idle && (idle_cnt_q != '1)) idle_cnt_d = idle_cnt_q + 32'd1;
            if (free_q && (page_cnt_q != '1))   page_cnt_d = page_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
            page_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            page_cnt_q <= page_cnt_d;
        end
    end

    assign idle_cnt = idle_cnt_q;
    assign page_cnt = page_cnt_q;
`endif

endmodule

// File: doc/sonic_tx_page_scheduler.md
Name: sonic_tx_page_scheduler

Overview:
- Read-side sequencer for the 66-bit transmit circular buffer, in the rd_clk (gearbox) domain.
- Counts pages the DMA path has fully written and generates the internal read address (sync ring and data ring share one address).
- Issues read strobes, frees pages back to the driver, and tells the gearbox when to substitute an idle block because no page is ready.

Parameters:
- NUM_PAGES, 32, pages in the Tx ring; must be a power of 2; 32 fills the 14-bit address space.
- BLKS_PER_PAGE, 496, 66-bit blocks per page (0x1F0).
- BLK_OFFSET, 16, first valid internal entry in each page (0x10).
- RD_LATENCY, 2, buffer read latency in clk_in cycles, from rd_address/rdreq to data_out; legal range 1..4.

Ports:
- clk_in  input  1  rd-side clock.
- reset  input  1  asynchronous, active-high reset.
- tx_enable  input  1  allows new pages to start transmitting.
- page_done  input  1  one-cycle pulse, already synchronized to clk_in; one more page fully written.
- blk_req  input  1  gearbox wants the next 66-bit block this cycle.
- rd_address  output  14  internal read address to both rings.
- rdreq  output  1  read strobe to the buffer.
- blk_valid  output  1  buffer data_out holds a real block; aligned to RD_LATENCY.
- blk_idle  output  1  gearbox must send an idle block; aligned to RD_LATENCY.
- page_free  output  1  one-cycle pulse; one page fully read and its slot reusable.
- pages_ready  output  6  complete, unread pages, counting the page currently being sent.
- overflow  output  1  sticky error flag.
- state  output  2  FSM state: 0 EMPTY, 1 SEND, 2 STOP.

Behaviour:
- Reset values:
  - state=EMPTY.
  - Page index pgn=0 and block counter blk=0, so rd_address=0x0010.
  - pages_ready=0.
  - rdreq, blk_valid, blk_idle, page_free and overflow all 0.
  - The RD_LATENCY pipeline is cleared.
- Address: rd_address = {pgn[4:0], blk[8:0]+BLK_OFFSET}. It is formed combinationally from registered pgn and blk, so it is stable during the cycle rdreq is high.
- pgn and blk change only in the cycle after an accepted read.
- Page accept: page_done with pages_ready<NUM_PAGES increments pages_ready.
- Page overflow: page_done with pages_ready==NUM_PAGES sets overflow; pages_ready does not change. overflow is cleared only by reset.
- rdreq = blk_req & (state==SEND). Only one rdreq is issued per blk_req cycle.
- Read progress on each rdreq:
  - If blk==BLKS_PER_PAGE-1: blk goes to 0, pgn goes to pgn+1 (wraps 31 to 0), pages_ready decrements, and page_free pulses in the next cycle.
  - Otherwise blk goes to blk+1.
- Simultaneous page accept and page completion: pages_ready is unchanged. The count never under- or overflows.
- Alignment: each blk_req cycle produces exactly one of blk_valid or blk_idle, RD_LATENCY cycles later.
  - blk_valid is produced if rdreq was high.
  - blk_idle is produced otherwise.
  - Cycles without blk_req produce neither.
- FSM transitions:
  - EMPTY to SEND: when pages_ready>0 and tx_enable (registered next-state).
  - SEND to EMPTY: on the final block of a page, when the resulting pages_ready==0 (a page_done in that same cycle counts toward it).
  - SEND to STOP: on the final block of a page, when tx_enable==0.
  - SEND holds otherwise, including when tx_enable drops mid-page. The page always finishes.
  - STOP to SEND: when tx_enable==1 and pages_ready>0.
  - STOP to EMPTY: when tx_enable==1 and pages_ready==0.
- Idle substitution: EMPTY and STOP answer every blk_req with blk_idle.
- Reset mid-page: pointers return to page 0. The driver must re-post pages after reset.

Optional Feature:
- Macro: SONIC_TX_SCHED_STATS_EN.
- When defined, adds two outputs and two counters:
  - idle_cnt, 32 bits: increments once per blk_idle.
  - page_cnt, 32 bits: increments once per page_free.
  - Both counters saturate at 0xFFFFFFFF, reset to 0, and clear synchronously on a new input stats_clr.
- When undefined, these ports and registers do not exist, and the other outputs are bit-identical.

Test Plan:
- Reset release with tx_enable=1, page_done=0, blk_req=1 for 10 cycles -> rdreq stays 0, rd_address=0x0010, and 10 blk_idle pulses arrive starting RD_LATENCY cycles after the first request.
- One page_done, then 496 consecutive blk_req -> rd_address steps 0x0010..0x01FF, exactly 496 blk_valid, one page_free after the last strobe, pages_ready 1 then 0, state returns to EMPTY, and the next blk_req gives blk_idle.
- 32 page_done, then 32×496 blk_req -> the last page reads 0x3E10..0x3FFF, pgn wraps and rd_address returns to 0x0010, 32 page_free pulses, overflow stays 0.
- 33 page_done with no reads -> pages_ready=32 and overflow=1 on the 33rd pulse; reading all pages leaves overflow at 1.
- pages_ready=1; page_done in the same cycle as block 495's rdreq -> pages_ready stays 1, state stays SEND, and the next rd_address=0x0210.
- tx_enable dropped at block 100 with 2 pages ready -> blocks 101..495 are still sent, then state=STOP and blk_idle is returned; raising tx_enable resumes at 0x0210.
